hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline.
- Tracks in-flight destination registers across DEPTH post-decode stages (default EX/MEM/WB).
- Per source operand, drives ID-stage forwarding selects, load-use stall and branch/jump redirect flush.
- Keeps saturating stall and flush counters for performance measurement.

Parameters:
DEPTH, 3, number of tracked stages after ID; slot 1 = EX, slot DEPTH = WB
REG_AW, 5, register address width
LOAD_AVAIL, 2, first slot index whose load result can be forwarded (2 = MEM output)
REDIRECT_STAGE, 2, slot index of the instruction that raises redirect
CNT_W, 32, performance counter width
SEL_W, 2, forwarding select width; integrator sets it to ceil(log2(DEPTH+1))

Ports:
clk  input  1  main clock
arst_n  input  1  asynchronous active-low reset
enable  input  1  global run enable; 0 freezes all state
id_valid  input  1  instruction in ID is valid
id_rs1  input  REG_AW  ID source register 1
id_rs2  input  REG_AW  ID source register 2
id_use_rs1  input  1  instruction reads rs1
id_use_rs2  input  1  instruction reads rs2
id_rd  input  REG_AW  ID destination register
id_reg_write  input  1  ID instruction writes rd
id_mem_read  input  1  ID instruction is a load
redirect  input  1  taken branch/jump resolved in slot REDIRECT_STAGE
stall  output  1  hold PC and IF/ID, insert bubble into EX
flush_id  output  1  invalidate IF/ID register
fwd_sel_1  output  SEL_W  0 = regfile, k = result of slot k
fwd_sel_2  output  SEL_W  same, for rs2
stall_count  output  CNT_W  cycles with stall=1 and enable=1
flush_count  output  CNT_W  cycles with redirect=1 and enable=1

Behaviour:
- Slot state: per slot k in 1..DEPTH, fields v, rd, we, ld. Reset clears all fields to 0.
- Reset values: stall=0, flush_id=0, fwd_sel_*=0, counters=0.
- Match rule, per operand with use=1 and rs!=0: find the lowest k (youngest) with v&we&(rd==rs).
- fwd_sel is that k, or 0 if there is no match, use=0 or rs==0.
- Forwarding selects are combinational from the slots and ID inputs: zero latency, valid in the same cycle.
- Load-use stall: stall=1 when id_valid, redirect=0, and either operand's youngest match has ld=1 and k<LOAD_AVAIL.
  - Default parameters: a load one instruction ahead stalls exactly 1 cycle.
  - When the stall condition holds, fwd_sel for the load-matched operand is don't-care; it is driven 0.
- Redirect: flush_id=redirect, combinational. Redirect has priority, so stall is forced 0 while redirect=1.
- Update on rising clk when enable=1:
  - slot1 <= (id_valid & !stall & !redirect) ? {1, id_rd, id_reg_write, id_mem_read} : bubble (all 0).
  - slot k+1 <= slot k, with v cleared if redirect & k<REDIRECT_STAGE (kills wrong-path instructions).
  - The redirecting slot itself advances normally.
- When enable=0: no slot or counter update. Combinational outputs still reflect current state.
- Counters: increment by 1 per qualifying enabled cycle and saturate at all-ones (no wrap).
  - stall_count and flush_count increment independently. They cannot both increment in one cycle because redirect masks stall.
- Slot DEPTH drops off on shift. Register-file write-before-read is assumed, so an instruction leaving WB needs no tracking.
- Asynchronous reset mid-operation immediately invalidates all slots and zeroes counters and outputs.
- x0 destinations are tracked but never matched.

Test Plan:
- Forwarding: issue ADD x5 then ADD x6,x5,x5 -> second cycle fwd_sel_1=1, fwd_sel_2=1, stall=0; with one NOP between -> fwd_sel=2; with two NOPs -> fwd_sel=3; with three NOPs -> 0.
- Load-use: LD x7 then ADD x8,x7,x1 -> stall=1 for exactly 1 cycle; EX bubble inserted; next cycle fwd_sel_1=2, stall=0; stall_count=1.
- Youngest wins: ADD x3 then SUB x3 then OR x9,x3,x0 -> fwd_sel_1=1 (SUB), fwd_sel_2=0 (x0 never forwarded).
- Redirect: slots hold A(slot2), B(slot1); redirect=1 with ID valid -> flush_id=1, stall=0 even if load-use pending; next cycle slot1 and slot2 invalid, slot3=A; flush_count increments by 1.
- Enable and saturation: enable=0 for 5 cycles with pending load-use -> state and counters frozen, stall stays 1. Preload counter near all-ones (CNT_W=4 build): 20 stall cycles -> stall_count holds at 15.
- Reset: assert arst_n=0 mid-stream between clock edges -> all outputs 0 immediately; after release, a dependent pair forwards correctly from an empty scoreboard.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for the in-order pipeline: tracks in-flight
// destinations after ID and derives forwarding selects, load-use stall and redirect flush.
module hazard_scoreboard #(
  parameter int DEPTH          = 3,
  parameter int REG_AW         = 5,
  parameter int LOAD_AVAIL     = 2,
  parameter int REDIRECT_STAGE = 2,
  parameter int CNT_W          = 32,
  parameter int SEL_W          = 2
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              redirect,
  output logic              stall,
  output logic              flush_id,
  output logic [SEL_W-1:0]  fwd_sel_1,
  output logic [SEL_W-1:0]  fwd_sel_2,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              ld;
  } slot_t;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             load_hazard;
  } match_t;

  slot_t slots [1:DEPTH];

  logic   stall_int;
  match_t m1, m2;

  // Scanning from the oldest slot down lets the youngest match overwrite older ones.
  function automatic match_t find_match(input logic [REG_AW-1:0] rs, input logic use_rs);
    match_t m;
    m = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (use_rs && (rs != '0) && slots[k].v && slots[k].we && (slots[k].rd == rs)) begin
        m.sel         = SEL_W'(k);
        m.load_hazard = slots[k].ld && (k < LOAD_AVAIL);
      end
    end
    return m;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    m1        = find_match(id_rs1, id_use_rs1);
    m2        = find_match(id_rs2, id_use_rs2);
    stall_int = id_valid && !redirect && (m1.load_hazard || m2.load_hazard);
    fwd_sel_1 = (stall_int && m1.load_hazard) ? '0 : m1.sel;
    fwd_sel_2 = (stall_int && m2.load_hazard) ? '0 : m2.sel;
  end

  assign stall    = stall_int;
  assign flush_id = redirect;

  // NOTE: the slot array is reset explicitly; stale valid bits would create false hazards.
  // NOTE: state uses non-blocking assignments so the shift reads pre-edge slot values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int k = 1; k <= DEPTH; k++) slots[k] <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else if (enable) begin
      slots[1] <= (id_valid && !stall_int && !redirect)
                  ? slot_t'{v: 1'b1, rd: id_rd, we: id_reg_write, ld: id_mem_read}
                  : slot_t'('0);
      for (int k = 1; k < DEPTH; k++) begin
        slots[k+1] <= slots[k];
        // Younger-than-redirect slots hold wrong-path instructions.
        if (redirect && (k < REDIRECT_STAGE)) slots[k+1].v <= 1'b0;
      end
      if (stall_int && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (redirect && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a driver pushes hand-computed expectations,
// a negedge monitor pops and compares them against the default and a CNT_W=4 build.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_n;
  logic        enable, id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, redirect;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        stall, flush_id;
  logic [1:0]  fwd_sel_1, fwd_sel_2;
  logic [31:0] stall_count, flush_count;

  logic        b_enable, b_valid, b_use_rs1, b_use_rs2, b_reg_write, b_mem_read, b_redirect;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic        b_stall, b_flush_id;
  logic [1:0]  b_fwd_sel_1, b_fwd_sel_2;
  logic [3:0]  b_stall_count, b_flush_count;

  hazard_scoreboard dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .redirect(redirect), .stall(stall), .flush_id(flush_id),
    .fwd_sel_1(fwd_sel_1), .fwd_sel_2(fwd_sel_2),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_scoreboard #(.CNT_W(4)) dut_sat (
    .clk(clk), .arst_n(arst_n), .enable(b_enable), .id_valid(b_valid),
    .id_rs1(b_rs1), .id_rs2(b_rs2), .id_use_rs1(b_use_rs1), .id_use_rs2(b_use_rs2),
    .id_rd(b_rd), .id_reg_write(b_reg_write), .id_mem_read(b_mem_read),
    .redirect(b_redirect), .stall(b_stall), .flush_id(b_flush_id),
    .fwd_sel_1(b_fwd_sel_1), .fwd_sel_2(b_fwd_sel_2),
    .stall_count(b_stall_count), .flush_count(b_flush_count)
  );

  typedef struct {
    string       name;
    logic        stall;
    logic        flush;
    logic [1:0]  s1;
    logic [1:0]  s2;
    bit          cnt;
    logic [31:0] sc;
    logic [31:0] fc;
    bit          sat;
    logic [3:0]  sat_sc;
  } exp_t;

  exp_t q[$];
  exp_t mon_r;
  int   total = 0;
  int   bad   = 0;

  // Monitor: outputs are presented every cycle; compare at the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      mon_r = q.pop_front();
      total++;
      if ({stall, flush_id, fwd_sel_1, fwd_sel_2} !== {mon_r.stall, mon_r.flush, mon_r.s1, mon_r.s2}) begin
        bad++;
        $display("FAIL %s: stall/flush/sel1/sel2 got %b/%b/%0d/%0d want %b/%b/%0d/%0d",
                 mon_r.name, stall, flush_id, fwd_sel_1, fwd_sel_2,
                 mon_r.stall, mon_r.flush, mon_r.s1, mon_r.s2);
      end
      if (mon_r.cnt) begin
        total++;
        if ({stall_count, flush_count} !== {mon_r.sc, mon_r.fc}) begin
          bad++;
          $display("FAIL %s counters: stall_count/flush_count got %0d/%0d want %0d/%0d",
                   mon_r.name, stall_count, flush_count, mon_r.sc, mon_r.fc);
        end
      end
      if (mon_r.sat) begin
        total++;
        if (b_stall_count !== mon_r.sat_sc) begin
          bad++;
          $display("FAIL %s sat stall_count got %0d want %0d", mon_r.name, b_stall_count, mon_r.sat_sc);
        end
      end
    end
  end

  task automatic push(input string name, input logic es, input logic ef,
                      input logic [1:0] e1, input logic [1:0] e2);
    exp_t r;
    r.name = name; r.stall = es; r.flush = ef; r.s1 = e1; r.s2 = e2;
    r.cnt = 1'b0; r.sc = '0; r.fc = '0; r.sat = 1'b0; r.sat_sc = '0;
    q.push_back(r);
  endtask

  task automatic expect_cnt(input logic [31:0] sc, input logic [31:0] fc);
    exp_t r;
    r = q[q.size()-1];
    r.cnt = 1'b1; r.sc = sc; r.fc = fc;
    q[q.size()-1] = r;
  endtask

  task automatic expect_sat(input logic [3:0] sc);
    exp_t r;
    r = q[q.size()-1];
    r.sat = 1'b1; r.sat_sc = sc;
    q[q.size()-1] = r;
  endtask

  task automatic step(input string name, input logic v,
                      input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic we, input logic ld,
                      input logic rdr, input logic en,
                      input logic es, input logic ef, input logic [1:0] e1, input logic [1:0] e2);
    @(posedge clk);
    #1;
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = we; id_mem_read = ld; redirect = rdr; enable = en;
    push(name, es, ef, e1, e2);
  endtask

  task automatic alu(input string name, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [1:0] e1, input logic [1:0] e2);
    step(name, 1, rs1, 1, rs2, 1, rd, 1, 0, 0, 1, 0, 0, e1, e2);
  endtask

  task automatic nop(input string name);
    step(name, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n = 1'b0;
    enable = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; redirect = 1'b0;
    b_enable = 1'b0; b_valid = 1'b0; b_rs1 = '0; b_rs2 = '0; b_use_rs1 = 1'b0; b_use_rs2 = 1'b0;
    b_rd = '0; b_reg_write = 1'b0; b_mem_read = 1'b0; b_redirect = 1'b0;

    nop("reset_state");
    expect_cnt(0, 0);
    #6 arst_n = 1'b1;

    // Forwarding distance 1..4
    alu("fwd1_producer", 5, 1, 2, 0, 0);
    alu("fwd1_consumer", 6, 5, 5, 1, 1);
    alu("fwd2_producer", 10, 1, 2, 0, 0);
    nop("fwd2_nop");
    alu("fwd2_consumer", 11, 10, 10, 2, 2);
    alu("fwd3_producer", 12, 1, 2, 0, 0);
    nop("fwd3_nop_a");
    nop("fwd3_nop_b");
    alu("fwd3_consumer", 13, 12, 12, 3, 3);
    alu("fwd4_producer", 14, 1, 2, 0, 0);
    nop("fwd4_nop_a");
    nop("fwd4_nop_b");
    nop("fwd4_nop_c");
    alu("fwd4_consumer", 15, 14, 14, 0, 0);

    // Load-use: one stall cycle, then forward from MEM; bubble visible afterwards
    step("ld_x7", 1, 1, 1, 0, 0, 7, 1, 1, 0, 1, 0, 0, 0, 0);
    step("ld_use_stall", 1, 7, 1, 1, 1, 8, 1, 0, 0, 1, 1, 0, 0, 0);
    step("ld_use_fwd", 1, 7, 1, 1, 1, 8, 1, 0, 0, 1, 0, 0, 2, 0);
    expect_cnt(1, 0);
    alu("ld_bubble_check", 9, 8, 7, 1, 3);

    // Youngest match wins, x0 never forwarded
    alu("yw_add_x3", 3, 1, 2, 0, 0);
    alu("yw_sub_x3", 3, 1, 2, 0, 0);
    alu("yw_or_x3_x0", 9, 3, 0, 1, 0);

    // Redirect with A in slot2, B (a load) in slot1 and a load-use pending
    step("rd_A_ld_x20", 1, 1, 1, 2, 1, 20, 1, 1, 0, 1, 0, 0, 0, 0);
    step("rd_B_ld_x21", 1, 1, 1, 2, 1, 21, 1, 1, 0, 1, 0, 0, 0, 0);
    step("redirect", 1, 21, 1, 0, 0, 22, 1, 0, 1, 1, 0, 1, 1, 0);
    alu("post_redirect", 23, 20, 21, 3, 0);
    expect_cnt(1, 1);

    // Enable freeze with a pending load-use
    step("en_ld_x24", 1, 1, 1, 0, 0, 24, 1, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step("frozen_stall", 1, 24, 1, 1, 1, 25, 1, 0, 0, 0, 1, 0, 0, 0);
      expect_cnt(1, 1);
    end
    step("unfrozen_stall", 1, 24, 1, 1, 1, 25, 1, 0, 0, 1, 1, 0, 0, 0);
    expect_cnt(1, 1);
    step("unfrozen_fwd", 1, 24, 1, 1, 1, 25, 1, 0, 0, 1, 0, 0, 2, 0);
    expect_cnt(2, 1);

    // Asynchronous reset between edges with a live dependency present
    alu("pre_reset_x26", 26, 1, 2, 0, 0);
    @(posedge clk);
    #1;
    id_valid = 1; id_rs1 = 26; id_use_rs1 = 1; id_rs2 = 26; id_use_rs2 = 1;
    id_rd = 27; id_reg_write = 1; id_mem_read = 0; redirect = 0; enable = 1;
    #1 arst_n = 1'b0;
    push("async_reset", 0, 0, 0, 0);
    expect_cnt(0, 0);
    @(negedge clk);
    #2 arst_n = 1'b1;
    alu("post_reset_prod", 28, 1, 2, 0, 0);
    alu("post_reset_cons", 29, 28, 28, 1, 1);
    expect_cnt(0, 0);

    // Saturation on the CNT_W=4 build: constant LD x7,0(x7) stalls every other cycle
    for (int i = 1; i <= 40; i++) begin
      nop("sat_idle");
      if (i == 1) begin
        b_enable = 1; b_valid = 1; b_rs1 = 7; b_use_rs1 = 1; b_rd = 7; b_reg_write = 1; b_mem_read = 1;
      end
      if (i == 29) expect_sat(14);
      if (i == 31) expect_sat(15);
    end
    nop("sat_final");
    expect_sat(15);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL queue_drain: %0d expectations left want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
